window_sequencer: RTL
=====================

// Module: window_sequencer
// PURPOSE
//  Streaming front-end for the windowing stage. Buffers serial 12-bit audio samples into
//  overlapping frames (FRAME_LEN samples, advancing HOP_LEN per frame) in a circular RAM.
//  For each complete frame it multiplies every sample by its window coefficient using one
//  shared multiplier, emitting the windowed samples as a valid/ready stream to the FFT stage.
// PARAMETERS
//  FRAME_LEN  256  samples per frame (power of 2); coefficient ROM depth
//  HOP_LEN    128  new samples between frame starts (1..FRAME_LEN)
//  BUF_DEPTH  512  circular buffer depth (power of 2, >= 2*FRAME_LEN)
//  COEF_FRAC  11   fractional bits of coef_data (unsigned Q1.11, 2048 = 1.0)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous reset, active-low
//  in_sample  in   12  input sample, signed two's complement
//  in_valid   in   1   in_sample valid
//  in_ready   out  1   sequencer accepts in_sample; transfer = in_valid & in_ready
//  coef_addr  out  8   window coefficient ROM address (log2 FRAME_LEN)
//  coef_data  in   12  coefficient, unsigned Q1.11, synchronous ROM, 1-cycle read latency
//  out_sample out  12  windowed sample, signed
//  out_valid  out  1   out_sample valid
//  out_ready  in   1   downstream accepts; transfer = out_valid & out_ready
//  out_first  out  1   qualifies out_sample as frame index 0
//  out_last   out  1   qualifies out_sample as frame index FRAME_LEN-1
//  busy       out  1   high in PRIME or EMIT state
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_first=0, out_last=0, busy=0, coef_addr=0, all
//   pointers/counters=0, pending=0, state=FILL. Buffer RAM is not cleared. Reset asserted
//   mid-frame aborts the frame; no partial output follows reset release.
//  Input: each accepted sample is written at wr_ptr; wr_ptr increments mod BUF_DEPTH.
//  Trigger: at the cycle the FRAME_LEN-th sample since reset is accepted, and then at every
//   HOP_LEN-th accepted sample after it. Frame base = wr_ptr(after write) - FRAME_LEN mod BUF_DEPTH.
//  FSM: FILL -> PRIME on trigger; PRIME issues buffer read (base+0) and coef_addr=0 -> EMIT.
//   EMIT: one sample/coef index per advance; after out_last handshake -> PRIME if pending
//   (back-to-back frame, pending cleared), else FILL.
//  Trigger during PRIME/EMIT: set pending and latch its base; no emission is skipped.
//  Backpressure: in_ready=0 when (pending=1 and next accept would trigger again) or when
//   (wr_ptr - rd_base_current) mod BUF_DEPTH == BUF_DEPTH-1 (no overwrite of unread data).
//  Pipeline (3 stages): address -> RAM/ROM data -> registered product/output. With
//   out_ready=1 held, trigger in cycle T gives first out_valid (out_first=1) in T+3 and
//   one sample per cycle thereafter; out_last on the FRAME_LEN-th output.
//  Stall: when out_valid=1 and out_ready=0, all stages, addresses and out_* hold stable;
//   input writes continue subject to in_ready.
//  Arithmetic: prod = signed(in_sample) * {1'b0,coef_data} (25-bit signed);
//   res = prod >>> COEF_FRAC (arithmetic, truncate toward -inf); saturate res to
//   [-2048, 2047] -> out_sample. Coef 2048 passes samples unchanged.
//  Simultaneous in/out handshakes in the same cycle are independent and both take effect.
//  Wrap-around: frame reads and writes wrap mod BUF_DEPTH with no gap or discontinuity.
// TESTING
//  1 Reset, then feed 256 samples with value 100 and coef ROM = 2048, out_ready=1 -> 256
//    outputs of value 100, out_first on #0, out_last on #255, first out_valid 3 cycles after trigger.
//  2 Feed a ramp 0..639, HOP_LEN=128 -> frames start at samples 0,128,256,384; the third
//    frame's out_sample[0] = 256 (coef 2048); the read pointer wraps past 511 cleanly.
//  3 Sample -2048 with coef 1024 -> -1024; sample 2047 with coef 2048 -> 2047; sample -1
//    with coef 1 -> -1 (floor of the arithmetic shift); no saturation false trips.
//  4 Hold out_ready=0 for 20 cycles mid-frame while in_valid=1 -> out_* stable and
//    in_ready drops at the pending/overwrite limit; no sample lost; sequence resumes exactly.
//  5 Feed input continuously with out_ready=1 -> back-to-back frames, PRIME-only gap of
//    3 cycles between out_last and the next out_first.
//  6 Assert reset at output index 100 -> next cycle out_valid=0, busy=0; after release,
//    256 new samples give a complete fresh frame.

Source files
------------

// File: rtl/window_sequencer.sv
// Windowing front-end: buffers serial 12-bit samples into overlapping frames in a
// circular RAM, then streams each frame multiplied by its window coefficient.
//
// state  | meaning
// -------+----------------------------------------------------------------
// FILL   | collecting input, no frame in flight
// PRIME  | issue the first read (base+0, coef 0) of the next frame
// EMIT   | issue remaining reads, drain pipeline until out_last handshake
module window_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int HOP_LEN   = 128,
  parameter int BUF_DEPTH = 512,
  parameter int COEF_FRAC = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [11:0]                  in_sample,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [$clog2(FRAME_LEN)-1:0] coef_addr,
  input  logic [11:0]                  coef_data,
  output logic [11:0]                  out_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         busy
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = IW + 1;
  localparam int PW = 25;

  localparam logic [AW-1:0] ONE_A       = AW'(1);
  localparam logic [AW-1:0] FRAME_LEN_A = AW'(FRAME_LEN);
  localparam logic [AW-1:0] FULL_DIST   = AW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FRAME_TC    = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] HOP_TC      = CW'(HOP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(FRAME_LEN - 1);
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2047);
  localparam logic signed [PW-1:0] SAT_MIN = -PW'(2048);

  typedef enum logic [1:0] {S_FILL, S_PRIME, S_EMIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic          filled_q, filled_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW-1:0] pend_base_q, pend_base_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          issued_all_q, issued_all_d;
  logic          v1_q, v1_d;
  logic          first1_q, first1_d;
  logic          last1_q, last1_d;
  logic          held_q, held_d;
  logic [11:0]   coef_hold_q, coef_hold_d;
  logic          out_valid_q, out_valid_d;
  logic [11:0]   out_sample_q, out_sample_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;

  logic [11:0]   mem [BUF_DEPTH];
  logic [11:0]   ram_rd_q;

  logic          accept, would_trig, trigger, buf_full, advance, issue, last_hs;
  logic [CW-1:0] trig_tc;
  logic [AW-1:0] new_base, rd_addr;
  logic [11:0]   coef_eff;
  logic signed [PW-1:0] samp_ext, coef_ext, prod, shifted;

  // Handshake qualifiers, trigger detection and flow control.
  always_comb begin
    busy       = (state_q != S_FILL);
    accept     = in_valid && in_ready;
    trig_tc    = filled_q ? HOP_TC : FRAME_TC;
    would_trig = (acc_cnt_q == trig_tc);
    // in_ready must not depend on in_valid, so the trigger uses the registered count
    buf_full   = busy && ((wr_ptr_q - rd_base_q) == FULL_DIST);
    in_ready   = !(pending_q && would_trig) && !buf_full;
    trigger    = accept && would_trig;
    new_base   = wr_ptr_q + ONE_A - FRAME_LEN_A;
    advance    = !out_valid_q || out_ready;
    issue      = advance && ((state_q == S_PRIME) ||
                             ((state_q == S_EMIT) && !issued_all_q));
    last_hs    = out_valid_q && out_ready && out_last_q;
    rd_addr    = rd_base_q + AW'(idx_q);
  end

  // Write pointer and accepted-sample counter toward the next trigger.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    acc_cnt_d = acc_cnt_q;
    filled_d  = filled_q;
    if (accept) begin
      wr_ptr_d  = wr_ptr_q + ONE_A;
      acc_cnt_d = trigger ? '0 : acc_cnt_q + CW'(1);
      filled_d  = filled_q || trigger;
    end
  end

  // Frame sequencing: next state, active read base and one-deep pending frame.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pend_base_d = pend_base_q;
    rd_base_d   = rd_base_q;
    case (state_q)
      S_FILL: begin
        if (trigger) begin
          rd_base_d = new_base;
          state_d   = S_PRIME;
        end
      end
      S_PRIME: begin
        if (issue) state_d = S_EMIT;
        if (trigger) begin
          pending_d   = 1'b1;
          pend_base_d = new_base;
        end
      end
      S_EMIT: begin
        if (last_hs) begin
          if (pending_q) begin
            state_d   = S_PRIME;
            rd_base_d = pend_base_q;
            pending_d = 1'b0;
          end else if (trigger) begin
            state_d   = S_PRIME;
            rd_base_d = new_base;
          end else begin
            state_d = S_FILL;
          end
        end else if (trigger) begin
          pending_d   = 1'b1;
          pend_base_d = new_base;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Read issue, stage-2 flags, coefficient hold across stalls and the multiply/saturate.
  always_comb begin
    idx_d        = idx_q;
    issued_all_d = issued_all_q;
    v1_d         = v1_q;
    first1_d     = first1_q;
    last1_d      = last1_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;

    // ROM output follows coef_addr, which moves on after issue; keep the value
    // belonging to the stalled stage-2 item until the pipeline advances again.
    held_d      = !advance;
    coef_hold_d = held_q ? coef_hold_q : coef_data;
    coef_eff    = held_q ? coef_hold_q : coef_data;

    samp_ext = PW'($signed(ram_rd_q));
    coef_ext = PW'($signed({1'b0, coef_eff}));
    prod     = samp_ext * coef_ext;
    shifted  = prod >>> COEF_FRAC;

    if (issue) begin
      idx_d        = idx_q + IW'(1);
      issued_all_d = (idx_q == IDX_LAST);
    end
    if (advance) begin
      v1_d        = issue;
      first1_d    = issue && (idx_q == '0);
      last1_d     = issue && (idx_q == IDX_LAST);
      out_valid_d = v1_q;
      out_first_d = first1_q;
      out_last_d  = last1_q;
      if (shifted > SAT_MAX)      out_sample_d = 12'h7FF;
      else if (shifted < SAT_MIN) out_sample_d = 12'h800;
      else                        out_sample_d = shifted[11:0];
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      wr_ptr_q     <= '0;
      acc_cnt_q    <= '0;
      filled_q     <= 1'b0;
      pending_q    <= 1'b0;
      rd_base_q    <= '0;
      pend_base_q  <= '0;
      idx_q        <= '0;
      issued_all_q <= 1'b0;
      v1_q         <= 1'b0;
      first1_q     <= 1'b0;
      last1_q      <= 1'b0;
      held_q       <= 1'b0;
      coef_hold_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      acc_cnt_q    <= acc_cnt_d;
      filled_q     <= filled_d;
      pending_q    <= pending_d;
      rd_base_q    <= rd_base_d;
      pend_base_q  <= pend_base_d;
      idx_q        <= idx_d;
      issued_all_q <= issued_all_d;
      v1_q         <= v1_d;
      first1_q     <= first1_d;
      last1_q      <= last1_d;
      held_q       <= held_d;
      coef_hold_q  <= coef_hold_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
    end
  end

  // Sample buffer: write on accept, registered read that holds during a stall.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= in_sample;
    if (advance) ram_rd_q <= mem[rd_addr];
  end

  assign coef_addr  = idx_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;

endmodule
